nios2_cordic_timer_master: RTL and testbench

Avalon-MM initiator that drives the 16-bit-register interval timer slave on behalf of fabric logic, such as the CORDIC datapath, without a CPU. It accepts high-level commands (configure, snapshot, acknowledge, status) and expands each into the required sequence of single 16-bit bus transfers. Its bus port connects directly to the timer's s1 slave port, and it optionally services the timer irq.

---
 rtl/nios2_cordic_timer_pkg.sv | 94 +++++++++
 rtl/nios2_cordic_timer_avm_xfer.sv | 48 ++++
 rtl/nios2_cordic_timer_master.sv | 170 +++++++++++++++++
 tb/tb_nios2_cordic_timer_master.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_cordic_timer_pkg.sv
// Shared types and register map for the CORDIC timer bus master.
// Micro-op table expanding each command into single 16-bit transfers.
package nios2_cordic_timer_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  typedef enum logic [1:0] {
    OP_CONFIG      = 2'd0,
    OP_SNAPSHOT    = 2'd1,
    OP_ACK_STATUS  = 2'd2,
    OP_READ_STATUS = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ      = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic        last;
  } uop_t;

  function automatic logic step_is_wr(cmd_op_e op, logic [1:0] step);
    return !(op == OP_READ_STATUS ||
             (op == OP_SNAPSHOT && step != 2'd0));
  endfunction

  function automatic uop_t get_uop(
    cmd_op_e     op,
    logic [1:0]  step,
    logic [31:0] period,
    logic        cont,
    logic        ien
  );
    uop_t u;
    u    = '0;
    u.wr = step_is_wr(op, step);
    unique case (op)
      OP_CONFIG: begin
        u.last = (step == 2'd3);
        case (step)
          2'd0: begin
            u.addr = REG_CONTROL;
            u.wdata[CTL_STOP] = 1'b1;
          end
          2'd1: begin
            u.addr  = REG_PERIODL;
            u.wdata = period[15:0];
          end
          2'd2: begin
            u.addr  = REG_PERIODH;
            u.wdata = period[31:16];
          end
          default: begin
            u.addr = REG_CONTROL;
            u.wdata[CTL_START] = 1'b1;
            u.wdata[CTL_CONT]  = cont;
            u.wdata[CTL_ITO]   = ien;
          end
        endcase
      end
      OP_SNAPSHOT: begin
        u.last = (step >= 2'd2);
        u.addr = (step >= 2'd2) ? REG_SNAPH : REG_SNAPL;
      end
      OP_ACK_STATUS: begin
        u.last = 1'b1;
        u.addr = REG_STATUS;
      end
      default: begin
        u.last = 1'b1;
        u.addr = REG_STATUS;
      end
    endcase
    return u;
  endfunction

endpackage

// File: rtl/nios2_cordic_timer_avm_xfer.sv
// Single Avalon-MM transfer engine: waitrequest hold and read-latency
// countdown. Bus is driven idle whenever no transfer is requested.
module nios2_cordic_timer_avm_xfer
  import nios2_cordic_timer_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic              wait_data,
  input  logic [2:0]        addr,
  input  logic [15:0]       wdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              xfer_done,
  output logic              data_valid,
  output logic [15:0]       rdata
);

  logic [1:0] lat_cnt;

  assign avm_chipselect = req;
  assign avm_write_n    = !(req && wr);
  assign avm_address    = req ? ADDR_W'(addr) : '0;
  assign avm_writedata  = (req && wr) ? wdata : '0;
  assign xfer_done      = req && !avm_waitrequest;
  assign data_valid     = wait_data &&
                          (lat_cnt == 2'(READ_LATENCY - 1));
  assign rdata          = avm_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (!wait_data || data_valid) begin
      lat_cnt <= '0;
    end else begin
      lat_cnt <= lat_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/nios2_cordic_timer_master.sv
// Command-driven Avalon-MM initiator for the 16-bit interval timer.
// Optional AUTO_ACK_EN: acknowledge timer irq autonomously while idle.
module nios2_cordic_timer_master
  import nios2_cordic_timer_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_continuous,
  input  logic              cmd_irq_en,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              irq_in,
  output logic              timeout_pulse
);

  state_e      state_q, state_n;
  logic [1:0]  step_q, step_n;
  cmd_op_e     op_q;
  logic [31:0] period_q;
  logic        cont_q;
  logic        ien_q;
  logic [15:0] lo_q;
  logic [31:0] rsp_q;
  logic        auto_q;
  logic        auto_go;
  logic        accept;
  uop_t        cur;
  logic        xfer_done;
  logic        data_valid;
  logic [15:0] rdata;

`ifdef AUTO_ACK_EN
  logic guard_q;

  assign auto_go       = (state_q == S_IDLE) && irq_in && !guard_q;
  assign timeout_pulse = (state_q == S_DONE) && auto_q;

  // Skip one idle cycle so the acknowledged irq can fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      guard_q <= 1'b0;
    end else begin
      guard_q <= (state_q == S_DONE) && auto_q;
    end
  end
`else
  logic unused_irq;

  assign unused_irq    = irq_in;
  assign auto_go       = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  assign cmd_ready = (state_q == S_IDLE) && !auto_go;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE) && !auto_q;
  assign rsp_data  = rsp_q;
  assign cur       = get_uop(op_q, step_q, period_q, cont_q, ien_q);

  nios2_cordic_timer_avm_xfer #(
    .READ_LATENCY(READ_LATENCY),
    .ADDR_W      (ADDR_W)
  ) u_xfer (
    .clk            (clk),
    .reset          (reset),
    .req            ((state_q == S_WRITE) || (state_q == S_READ)),
    .wr             (state_q == S_WRITE),
    .wait_data      (state_q == S_WAIT_DATA),
    .addr           (cur.addr),
    .wdata          (cur.wdata),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .xfer_done      (xfer_done),
    .data_valid     (data_valid),
    .rdata          (rdata)
  );

  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    unique case (state_q)
      S_IDLE: begin
        step_n = 2'd0;
        if (auto_go) begin
          state_n = S_WRITE;
        end else if (accept) begin
          state_n = step_is_wr(cmd_op_e'(cmd_op), 2'd0) ?
                    S_WRITE : S_READ;
        end
      end
      S_WRITE, S_WAIT_DATA: begin
        if ((state_q == S_WRITE) ? xfer_done : data_valid) begin
          if (cur.last) begin
            state_n = S_DONE;
          end else begin
            step_n  = step_q + 2'd1;
            state_n = step_is_wr(op_q, step_q + 2'd1) ?
                      S_WRITE : S_READ;
          end
        end
      end
      S_READ: begin
        if (xfer_done) state_n = S_WAIT_DATA;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      op_q     <= OP_CONFIG;
      period_q <= '0;
      cont_q   <= 1'b0;
      ien_q    <= 1'b0;
      lo_q     <= '0;
      rsp_q    <= '0;
      auto_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      step_q  <= step_n;
      if (state_q == S_IDLE) begin
        if (auto_go) begin
          op_q   <= OP_ACK_STATUS;
          auto_q <= 1'b1;
        end else if (accept) begin
          op_q     <= cmd_op_e'(cmd_op);
          period_q <= cmd_period;
          cont_q   <= cmd_continuous;
          ien_q    <= cmd_irq_en;
          auto_q   <= 1'b0;
        end
      end
      if (state_q == S_WAIT_DATA && data_valid) begin
        if (!cur.last) begin
          lo_q <= rdata;
        end else if (op_q == OP_SNAPSHOT) begin
          rsp_q <= {rdata, lo_q};
        end else begin
          rsp_q <= {30'b0, rdata[1:0]};
        end
      end
      if (state_q == S_WRITE && xfer_done && cur.last && !auto_q) begin
        rsp_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nios2_cordic_timer_master.sv
// Directed bench for the timer bus master (latency 1 and 3 instances).
// Expected transfer lists and cycle offsets are written out by hand.
module tb_nios2_cordic_timer_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_valid3 = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_period = '0;
  logic        cmd_continuous = 1'b0;
  logic        cmd_irq_en = 1'b0;
  logic        waitreq = 1'b0;
  logic        irq = 1'b0;
  logic [15:0] status_val = 16'h0003;

  logic        cmd_ready, cmd_ready3;
  logic        rsp_valid, rsp_valid3;
  logic [31:0] rsp_data, rsp_data3;
  logic        busy, busy3;
  logic [2:0]  address, address3;
  logic        cs, cs3, write_n, write_n3;
  logic [15:0] wdata, wdata3;
  logic [15:0] rdata, rdata3;
  logic        tpulse, tpulse3;
  logic [15:0] pipe3 [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nios2_cordic_timer_master #(.READ_LATENCY(1), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period),
    .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .avm_address(address), .avm_chipselect(cs),
    .avm_write_n(write_n), .avm_writedata(wdata),
    .avm_readdata(rdata), .avm_waitrequest(waitreq),
    .irq_in(irq), .timeout_pulse(tpulse)
  );

  nios2_cordic_timer_master #(.READ_LATENCY(3), .ADDR_W(3)) dut3 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_period(cmd_period),
    .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3),
    .avm_address(address3), .avm_chipselect(cs3),
    .avm_write_n(write_n3), .avm_writedata(wdata3),
    .avm_readdata(rdata3), .avm_waitrequest(1'b0),
    .irq_in(1'b0), .timeout_pulse(tpulse3)
  );

  function automatic logic [15:0] slave_val(input logic [2:0] a);
    case (a)
      3'd0:    return status_val;
      3'd4:    return 16'h1234;
      3'd5:    return 16'hABCD;
      default: return 16'h0000;
    endcase
  endfunction

  // Read data is valid only in its latency slot, garbage otherwise.
  always @(posedge clk) begin
    rdata    <= (cs && write_n && !waitreq) ? slave_val(address) : 16'hDEAD;
    pipe3[0] <= (cs3 && write_n3) ? slave_val(address3) : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata3 = pipe3[2];

  int cyc = 0;
  int acc_cyc = 0, acc_n = 0, acc3_cyc = 0, acc3_n = 0;
  int tp_n = 0, cs_n = 0;
  int wr_a[$], wr_d[$], wr_c[$], rd_a[$], rd_c[$];
  int rsp_c[$], rsp3_c[$];
  logic [31:0] rsp_d[$], rsp3_d[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && cmd_valid && cmd_ready) begin
      acc_cyc <= cyc;
      acc_n   <= acc_n + 1;
    end
    if (!reset && cmd_valid3 && cmd_ready3) begin
      acc3_cyc <= cyc;
      acc3_n   <= acc3_n + 1;
    end
    if (cs) cs_n <= cs_n + 1;
    if (cs && !waitreq) begin
      if (!write_n) begin
        wr_a.push_back(int'(address));
        wr_d.push_back(int'(wdata));
        wr_c.push_back(cyc);
      end else begin
        rd_a.push_back(int'(address));
        rd_c.push_back(cyc);
      end
    end
    if (rsp_valid) begin
      rsp_c.push_back(cyc);
      rsp_d.push_back(rsp_data);
    end
    if (rsp_valid3) begin
      rsp3_c.push_back(cyc);
      rsp3_d.push_back(rsp_data3);
    end
    if (tpulse) tp_n <= tp_n + 1;
  end

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    rd_a.delete(); rd_c.delete();
    rsp_c.delete(); rsp_d.delete();
    rsp3_c.delete(); rsp3_d.delete();
    tp_n = 0;
  endtask

  task automatic send_cmd(input bit d3, input logic [1:0] op,
                          input logic [31:0] per, input logic c,
                          input logic ie);
    int n;
    n = 0;
    @(negedge clk);
    cmd_op = op; cmd_period = per;
    cmd_continuous = c; cmd_irq_en = ie;
    if (d3) cmd_valid3 = 1'b1; else cmd_valid = 1'b1;
    while (!(d3 ? cmd_ready3 : cmd_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(d3 ? cmd_ready3 : cmd_ready)) begin
      total++;
      $display("FAIL accept: cmd_ready stuck low (dut3=%0d)", d3);
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_valid3 = 1'b0;
  endtask

  task automatic wait_rsp(input bit d3, input int cnt);
    int n;
    n = 0;
    while ((d3 ? rsp3_c.size() : rsp_c.size()) < cnt && n < 60) begin
      @(negedge clk);
      n++;
    end
    if ((d3 ? rsp3_c.size() : rsp_c.size()) < cnt) begin
      total++;
      $display("FAIL rsp_timeout: no rsp_valid (dut3=%0d)", d3);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({cmd_ready, rsp_valid, busy, tpulse, cs, write_n} !== 6'b100001 ||
        address !== 3'd0 || wdata !== 16'h0 || rsp_data !== 32'h0) begin
      $display("FAIL reset: rdy=%b rv=%b busy=%b tp=%b cs=%b wn=%b a=%0d wd=%h rd=%h required 1 0 0 0 0 1 0 0000 00000000",
               cmd_ready, rsp_valid, busy, tpulse, cs, write_n,
               address, wdata, rsp_data);
    end else passed++;
  endtask

  task automatic test_snapshot();
    int t;
    clear_logs();
    send_cmd(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
    wait_rsp(1'b0, 1);
    t = acc_cyc;
    total++;
    if (wr_a.size() !== 1 || wr_a[0] !== 4 || wr_d[0] !== 0 ||
        wr_c[0] !== t + 1) begin
      $display("FAIL snap_write: n=%0d a=%0d d=%h c=%0d required 1 4 0000 %0d",
               wr_a.size(), wr_a[0], wr_d[0], wr_c[0], t + 1);
    end else passed++;
    total++;
    if (rd_a.size() !== 2 || rd_a[0] !== 4 || rd_a[1] !== 5 ||
        rd_c[0] !== t + 2 || rd_c[1] !== t + 4) begin
      $display("FAIL snap_reads: n=%0d a=%0d,%0d c=%0d,%0d required 4,5 at %0d,%0d",
               rd_a.size(), rd_a[0], rd_a[1], rd_c[0], rd_c[1], t + 2, t + 4);
    end else passed++;
    total++;
    if (rsp_d[0] !== 32'hABCD1234 || rsp_c[0] !== t + 6) begin
      $display("FAIL snap_rsp: data=%h cyc=%0d required abcd1234 at %0d",
               rsp_d[0], rsp_c[0], t + 6);
    end else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (rsp_data !== 32'hABCD1234 || rsp_valid !== 1'b0) begin
      $display("FAIL snap_hold: data=%h rv=%b required abcd1234 0",
               rsp_data, rsp_valid);
    end else passed++;
  endtask

  task automatic test_config();
    int t;
    int ea[4] = '{1, 2, 3, 1};
    int ed[4] = '{16'h0008, 16'h86A0, 16'h0001, 16'h0007};
    clear_logs();
    send_cmd(1'b0, 2'd0, 32'h000186A0, 1'b1, 1'b1);
    wait_rsp(1'b0, 1);
    t = acc_cyc;
    total++;
    if (wr_a.size() !== 4 || rd_a.size() !== 0) begin
      $display("FAIL cfg_count: writes=%0d reads=%0d required 4 0",
               wr_a.size(), rd_a.size());
    end else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wr_a[i] !== ea[i] || wr_d[i] !== ed[i] || wr_c[i] !== t + 1 + i) begin
          $display("FAIL cfg_write%0d: a=%0d d=%h c=%0d required %0d %h %0d",
                   i, wr_a[i], wr_d[i], wr_c[i], ea[i], ed[i], t + 1 + i);
        end else passed++;
      end
    end
    total++;
    if (rsp_d[0] !== 32'h0 || rsp_c[0] !== t + 5) begin
      $display("FAIL cfg_rsp: data=%h cyc=%0d required 00000000 at %0d",
               rsp_d[0], rsp_c[0], t + 5);
    end else passed++;
    clear_logs();
    send_cmd(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    wait_rsp(1'b0, 1);
    total++;
    if (wr_a.size() !== 4 || wr_d[1] !== 0 || wr_d[2] !== 0 ||
        wr_d[3] !== 16'h0004) begin
      $display("FAIL cfg_zero: n=%0d lo=%h hi=%h ctl=%h required 4 0000 0000 0004",
               wr_a.size(), wr_d[1], wr_d[2], wr_d[3]);
    end else passed++;
  endtask

  task automatic test_ack_status();
    int t;
    clear_logs();
    send_cmd(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
    wait_rsp(1'b0, 1);
    clear_logs();
    send_cmd(1'b0, 2'd2, 32'h0, 1'b0, 1'b0);
    wait_rsp(1'b0, 1);
    t = acc_cyc;
    total++;
    if (wr_a.size() !== 1 || wr_a[0] !== 0 || wr_d[0] !== 0 ||
        wr_c[0] !== t + 1 || rsp_d[0] !== 32'h0 || rsp_c[0] !== t + 2) begin
      $display("FAIL ack: n=%0d a=%0d d=%h rsp=%h rc=%0d required 1 0 0000 00000000 %0d",
               wr_a.size(), wr_a[0], wr_d[0], rsp_d[0], rsp_c[0], t + 2);
    end else passed++;
  endtask

  task automatic test_read_status();
    int t;
    clear_logs();
    status_val = 16'h0003;
    send_cmd(1'b0, 2'd3, 32'h0, 1'b0, 1'b0);
    wait_rsp(1'b0, 1);
    t = acc_cyc;
    total++;
    if (rsp_d[0] !== 32'h3 || rsp_c[0] !== t + 3 || rd_a.size() !== 1 ||
        rd_a[0] !== 0 || wr_a.size() !== 0) begin
      $display("FAIL status_rl1: data=%h cyc=%0d required 00000003 at %0d",
               rsp_d[0], rsp_c[0], t + 3);
    end else passed++;
    clear_logs();
    status_val = 16'hFFFE;
    send_cmd(1'b0, 2'd3, 32'h0, 1'b0, 1'b0);
    wait_rsp(1'b0, 1);
    total++;
    if (rsp_d[0] !== 32'h2) begin
      $display("FAIL status_mask: data=%h required 00000002", rsp_d[0]);
    end else passed++;
    clear_logs();
    status_val = 16'h0003;
    send_cmd(1'b1, 2'd3, 32'h0, 1'b0, 1'b0);
    wait_rsp(1'b1, 1);
    t = acc3_cyc;
    total++;
    if (rsp3_d[0] !== 32'h3 || rsp3_c[0] !== t + 5) begin
      $display("FAIL status_rl3: data=%h cyc=%0d required 00000003 at %0d",
               rsp3_d[0], rsp3_c[0], t + 5);
    end else passed++;
    clear_logs();
    send_cmd(1'b1, 2'd1, 32'h0, 1'b0, 1'b0);
    wait_rsp(1'b1, 1);
    t = acc3_cyc;
    total++;
    if (rsp3_d[0] !== 32'hABCD1234 || rsp3_c[0] !== t + 10) begin
      $display("FAIL snap_rl3: data=%h cyc=%0d required abcd1234 at %0d",
               rsp3_d[0], rsp3_c[0], t + 10);
    end else passed++;
  endtask

  task automatic test_waitrequest();
    int t, n0;
    clear_logs();
    send_cmd(1'b0, 2'd0, 32'h000186A0, 1'b1, 1'b1);
    t  = acc_cyc;
    n0 = acc_n;
    @(negedge clk);
    waitreq = 1'b1;
    cmd_op = 2'd3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (address !== 3'd2 || wdata !== 16'h86A0 || cs !== 1'b1 ||
          write_n !== 1'b0 || cmd_ready !== 1'b0) begin
        $display("FAIL wait_hold%0d: a=%0d d=%h cs=%b wn=%b rdy=%b required 2 86a0 1 0 0",
                 i, address, wdata, cs, write_n, cmd_ready);
      end else passed++;
    end
    waitreq = 1'b0;
    cmd_valid = 1'b0;
    wait_rsp(1'b0, 1);
    total++;
    if (rsp_c[0] !== t + 8 || wr_a.size() !== 4 || wr_c[1] !== t + 5) begin
      $display("FAIL wait_timing: rsp=%0d w2=%0d n=%0d required %0d %0d 4",
               rsp_c[0], wr_c[1], wr_a.size(), t + 8, t + 5);
    end else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (acc_n !== n0 || rsp_c.size() !== 1) begin
      $display("FAIL busy_ignore: accepts=%0d rsps=%0d required %0d 1",
               acc_n, rsp_c.size(), n0);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send_cmd(1'b0, 2'd0, 32'h000186A0, 1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (cs !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
        write_n !== 1'b1) begin
      $display("FAIL reset_mid: cs=%b rdy=%b busy=%b wn=%b required 0 1 0 1",
               cs, cmd_ready, busy, write_n);
    end else passed++;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (rsp_c.size() !== 0 || busy !== 1'b0) begin
      $display("FAIL reset_norsp: rsps=%0d busy=%b required 0 0",
               rsp_c.size(), busy);
    end else passed++;
  endtask

  task automatic test_auto_ack();
`ifdef AUTO_ACK_EN
    int n0;
    clear_logs();
    n0 = acc_n;
    status_val = 16'h0001;
    @(negedge clk);
    cmd_op = 2'd3;
    cmd_valid = 1'b1;
    irq = 1'b1;
    for (int i = 0; i < 30 && acc_n == n0; i++) begin
      @(negedge clk);
      if (tpulse) irq = 1'b0;
    end
    cmd_valid = 1'b0;
    irq = 1'b0;
    wait_rsp(1'b0, 1);
    repeat (3) @(negedge clk);
    total++;
    if (wr_a.size() !== 1 || wr_a[0] !== 0 || wr_d[0] !== 0 ||
        wr_c[0] >= acc_cyc) begin
      $display("FAIL auto_write: n=%0d a=%0d d=%h wc=%0d acc=%0d required 1 0 0000 before accept",
               wr_a.size(), wr_a[0], wr_d[0], wr_c[0], acc_cyc);
    end else passed++;
    total++;
    if (tp_n !== 1 || rsp_c.size() !== 1 || rsp_d[0] !== 32'h1) begin
      $display("FAIL auto_pulse: pulses=%0d rsps=%0d data=%h required 1 1 00000001",
               tp_n, rsp_c.size(), rsp_d[0]);
    end else passed++;
    status_val = 16'h0003;
`else
    int c0;
    clear_logs();
    c0 = cs_n;
    @(negedge clk);
    irq = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (cs_n !== c0 || tp_n !== 0 || tpulse !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL no_auto: cs_cycles=%0d pulses=%0d rdy=%b required %0d 0 1",
               cs_n, tp_n, cmd_ready, c0);
    end else passed++;
    irq = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_config();
    test_ack_status();
    test_read_status();
    test_waitrequest();
    test_reset_mid();
    test_auto_ack();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
